// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared uart_tx arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              busy;
  logic              err_timeout;

  // master: requesters plus the uart_tx byte engine; slave: the arbiter itself
  modport master (
    output req, req_data, req_last, tx_done,
    input  req_ready, grant, tx_data, tx_start, busy, err_timeout
  );

  modport slave (
    input  req, req_data, req_last, tx_done,
    output req_ready, grant, tx_data, tx_start, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one uart_tx; req->grant 1 clk, ->tx_start 3 clk; bytes paced by tx_done.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum byte after each completed message.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0]  CNT_END  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW:0]    NREQ_W   = IW1'(NREQ);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
`ifdef UART_ARB_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t          state, state_d;
  logic [IW-1:0]   gnt_idx, gnt_idx_d;
  logic [IW-1:0]   rr_ptr, rr_d;
  logic [NREQ-1:0] grant, grant_d;
  logic [NREQ-1:0] req_ready, req_ready_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            err_q, err_d;
  logic            last_q, last_d;
  logic            tx_done_q;
  logic [CW-1:0]   cnt, cnt_d;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic            in_ck_q, in_ck_d;
`endif

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     scan;
  logic [7:0]      sel_data;
  logic            gnt_req;
  logic            done_evt;

  assign sel_data = bus.req_data[{gnt_idx, 3'b000} +: 8];
  assign gnt_req  = bus.req[gnt_idx];
  assign done_evt = bus.tx_done & ~tx_done_q;

  // Scan downwards so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + IW1'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (bus.req[scan[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state;
    gnt_idx_d   = gnt_idx;
    grant_d     = grant;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;
    last_d      = last_q;
    rr_d        = rr_ptr;
    cnt_d       = cnt;
`ifdef UART_ARB_CHECKSUM_EN
    csum_d      = csum_q;
    in_ck_d     = in_ck_q;
`endif
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_idx_d = pick_idx;
          grant_d   = ONE_HOT0 << pick_idx;
          state_d   = S_LOAD;
`ifdef UART_ARB_CHECKSUM_EN
          csum_d    = 8'h00;
          in_ck_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (gnt_req) begin
          tx_data_d   = sel_data;
          last_d      = bus.req_last[gnt_idx];
          req_ready_d = grant;
          state_d     = S_SEND;
`ifdef UART_ARB_CHECKSUM_EN
          csum_d      = csum_q ^ sel_data;
`endif
        end else begin
          // Requester withdrew before its byte was taken: nothing goes on the line.
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (done_evt) begin
          if (last_q || !gnt_req) state_d = S_DONE;
          else                    state_d = S_LOAD;
`ifdef UART_ARB_CHECKSUM_EN
          if (last_q && !in_ck_q) state_d = S_CKSUM;
`endif
        end else if (cnt == CNT_END) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt != '1) begin
          cnt_d = cnt + CW'(1);
        end
      end
`ifdef UART_ARB_CHECKSUM_EN
      S_CKSUM: begin
        tx_data_d = csum_q;
        in_ck_d   = 1'b1;
        state_d   = S_SEND;
      end
`endif
      S_DONE: begin
        grant_d = '0;
        rr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      req_ready  <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      cnt        <= '0;
`ifdef UART_ARB_CHECKSUM_EN
      csum_q     <= 8'h00;
      in_ck_q    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      gnt_idx    <= gnt_idx_d;
      rr_ptr     <= rr_d;
      grant      <= grant_d;
      req_ready  <= req_ready_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      last_q     <= last_d;
      tx_done_q  <= bus.tx_done;
      cnt        <= cnt_d;
`ifdef UART_ARB_CHECKSUM_EN
      csum_q     <= csum_d;
      in_ck_q    <= in_ck_d;
`endif
    end
  end

  assign bus.grant       = grant;
  assign bus.req_ready   = req_ready;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.err_timeout = err_q;
  assign bus.busy        = (state != S_IDLE);

endmodule
